ubacc_16_64: RTL and testbench

- Streaming accumulator that sits directly upstream of the 16+64 unsigned adder core and owns its running-sum register.
- Accepts 16-bit unsigned samples over a valid/ready handshake and adds each one into a 64-bit accumulator through one combinational UBRCL_15_0_63_0 instance (X = sample, Y = accumulator).
- Captures carry-out as sticky overflow.
- Emits one framed result per in_last beat to a downstream consumer over a second valid/ready handshake.

---
 rtl/ubacc_pkg.sv | 23 ++
 rtl/UBRCL_15_0_63_0.sv | 30 +++
 rtl/ubacc_16_64.sv | 104 ++++++++++
 tb/tb_ubacc_16_64.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ubacc_pkg.sv
// ============================================================================
// Module   : ubacc_pkg
// Purpose  : Shared widths, counter limit and FSM state type for ubacc_16_64.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ubacc_pkg;

  localparam int IN_W  = 16;
  localparam int ACC_W = 64;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ACC   = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/UBRCL_15_0_63_0.sv
// ============================================================================
// Module   : UBRCL_15_0_63_0
// Purpose  : Combinational 16+64-bit unsigned adder with carry-out in S[64].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module UBRCL_15_0_63_0 (
  input  logic [15:0] X,
  input  logic [63:0] Y,
  output logic [64:0] S
);

  logic [63:0] w_x;
  logic [64:0] w_c;

  assign w_x    = {48'd0, X};
  assign w_c[0] = 1'b0;

  // Plain ripple chain; the carry out of the top bit becomes S[64].
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign S[i]     = w_x[i] ^ Y[i] ^ w_c[i];
    assign w_c[i+1] = (w_x[i] & Y[i]) | (w_c[i] & (w_x[i] ^ Y[i]));
  end

  assign S[64] = w_c[64];

endmodule

`default_nettype wire

// File: rtl/ubacc_16_64.sv
// ============================================================================
// Module   : ubacc_16_64
// Purpose  : Framed streaming accumulator with sticky overflow and sample count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ubacc_16_64
  import ubacc_pkg::*;
#(
  parameter int CNT_W = ubacc_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_last,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_ovf,
  output logic [CNT_W-1:0]       out_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t               r_state;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_out_valid;
  logic [ACC_W-1:0]     r_out_sum;
  logic                 r_out_ovf;
  logic [CNT_W-1:0]     r_out_count;

  logic [ACC_W:0]       w_sum;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_ovf_next;

  UBRCL_15_0_63_0 u_add (
    .X (in_data),
    .Y (r_acc),
    .S (w_sum)
  );

  // in_ready is a function of state and clr only, keeping handshakes decoupled.
  assign in_ready   = (r_state == ACC) & ~clr;
  assign w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
  assign w_ovf_next = r_ovf | w_sum[ACC_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
          end else if (in_valid) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= w_ovf_next;
            r_cnt <= w_cnt_next;
            if (in_last) begin
              r_out_sum   <= w_sum[ACC_W-1:0];
              r_out_ovf   <= w_ovf_next;
              r_out_count <= w_cnt_next;
              r_out_valid <= 1'b1;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_out_count;

endmodule

`default_nettype wire

// File: tb/tb_ubacc_16_64.sv
// ============================================================================
// Module   : tb_ubacc_16_64
// Purpose  : Directed self-checking bench for ubacc_16_64 (4-bit sample counter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ubacc_16_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_ovf;
  logic [3:0]  out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ubacc_16_64 #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf",   out_ovf,   0);
    check("rst_in_ready",  in_ready,  1);

    // Frame 1,2,3
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    check("f1_no_early_valid", out_valid, 0);
    beat(16'd3, 1'b1);
    check("f1_out_valid", out_valid, 1);
    check("f1_out_sum",   out_sum,   6);
    check("f1_out_count", out_count, 3);
    check("f1_out_ovf",   out_ovf,   0);
    check("f1_in_ready_drain", in_ready, 0);
    step();
    check("f1_valid_drop", out_valid, 0);
    check("f1_back_acc",   in_ready,  1);

    // Wrap-around with a preloaded accumulator
    force dut.r_acc = 64'hFFFF_FFFF_FFFF_FFF0;
    step();
    release dut.r_acc;
    beat(16'h0020, 1'b1);
    check("wrap_out_valid", out_valid, 1);
    check("wrap_out_sum",   out_sum,   64'h10);
    check("wrap_out_ovf",   out_ovf,   1);
    check("wrap_out_count", out_count, 1);
    step();
    beat(16'd5, 1'b1);
    check("after_wrap_sum", out_sum, 5);
    check("after_wrap_ovf", out_ovf, 0);
    step();

    // Backpressure
    out_ready = 1'b0;
    beat(16'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_sum",   out_sum,   7);
      check("bp_out_count", out_count, 1);
      check("bp_in_ready",  in_ready,  0);
      clr = (i == 2);
      step();
    end
    clr = 1'b0;
    check("bp_hold_after_clr", out_sum, 7);
    out_ready = 1'b1;
    step();
    check("bp_transfer_done", out_valid, 0);
    check("bp_in_ready_next", in_ready,  1);
    check("bp_sum_held",      out_sum,   7);

    // clr mid-frame
    beat(16'd10, 1'b0);
    beat(16'd20, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'd99;
    #1;
    check("clr_in_ready", in_ready, 0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_no_output", out_valid, 0);
    beat(16'd4, 1'b1);
    check("clr_out_sum",   out_sum,   4);
    check("clr_out_count", out_count, 1);
    check("clr_out_ovf",   out_ovf,   0);
    step();

    // Reset mid-frame
    beat(16'd100, 1'b0);
    beat(16'd200, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_sum",   out_sum,   0);
    beat(16'd9, 1'b1);
    check("mrst_out_sum2",  out_sum,   9);
    check("mrst_out_count", out_count, 1);
    check("mrst_out_ovf",   out_ovf,   0);
    step();

    // Count saturation at 15 with a 4-bit counter
    for (int i = 1; i <= 20; i++) beat(16'd1, i == 20);
    check("sat_out_valid", out_valid, 1);
    check("sat_out_count", out_count, 15);
    check("sat_out_sum",   out_sum,   20);
    step();
    check("sat_drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
